rtc_stopwatch_ctrl: RTL and testbench



---
 rtl/rtc_ctrl_pkg.sv | 19 +
 rtl/rtc_edge_sync.sv | 23 ++
 rtl/rtc_stopwatch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rtc_stopwatch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_ctrl_pkg.sv
// Shared types and default widths for the stopwatch controller.
// The RTC_LAP_FIFO_EN macro selects the lap FIFO in rtc_stopwatch_ctrl.
package rtc_ctrl_pkg;

  localparam int COUNT_W_DEF   = 24;
  localparam int LAP_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  function automatic logic counts_enabled(input state_t st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/rtc_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw button.
// The pulse is high for the single cycle after the second flop first sees the press.
module rtc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [2:0] sync_r;

  // Shift chain: [0],[1] synchronize, [2] remembers the previous synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], din};
    end
  end

  assign pulse = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/rtc_stopwatch_ctrl.sv
// Stopwatch control FSM with display freeze, overflow handling and lap capture.
// Define RTC_LAP_FIFO_EN for a LAP_DEPTH-entry lap FIFO; otherwise a single lap register.
module rtc_stopwatch_ctrl
  import rtc_ctrl_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int LAP_DEPTH = LAP_DEPTH_DEF
) (
  input  logic               i_sclk,
  input  logic               i_reset,
  input  logic               i_start_stop,
  input  logic               i_lap,
  input  logic               i_clear,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_lap_rd,
  output logic               o_countinit,
  output logic               o_countenb,
  output logic [COUNT_W-1:0] o_display,
  output logic               o_overflow,
  output logic [COUNT_W-1:0] o_lap_data,
  output logic               o_lap_valid,
  output logic               o_lap_empty,
  output logic               o_lap_full
);

  state_t state_r, state_nx;
  logic   start_p, lap_p, clear_p;
  logic   start_win, lap_win;
  logic   count_max, enter_lap, enter_idle;

  rtc_edge_sync u_sync_start (.clk(i_sclk), .rst(i_reset), .din(i_start_stop), .pulse(start_p));
  rtc_edge_sync u_sync_lap   (.clk(i_sclk), .rst(i_reset), .din(i_lap),        .pulse(lap_p));
  rtc_edge_sync u_sync_clear (.clk(i_sclk), .rst(i_reset), .din(i_clear),      .pulse(clear_p));

  assign count_max = &i_count;

  // Next-state logic; saturation overrides buttons, and clear > start > lap.
  always_comb begin
    start_win = start_p & ~clear_p;
    lap_win   = lap_p & ~clear_p & ~start_p;
    state_nx  = state_r;
    if (count_max && o_countenb) begin
      state_nx = ST_PAUSE;
    end else begin
      case (state_r)
        ST_IDLE:  if (start_win) state_nx = ST_RUN; else state_nx = ST_IDLE;
        ST_RUN:   if (start_win) state_nx = ST_PAUSE;
                  else if (lap_win) state_nx = ST_LAP;
                  else state_nx = ST_RUN;
        ST_PAUSE: if (clear_p) state_nx = ST_IDLE;
                  else if (start_win) state_nx = ST_RUN;
                  else state_nx = ST_PAUSE;
        ST_LAP:   if (start_win) state_nx = ST_PAUSE;
                  else if (lap_win) state_nx = ST_RUN;
                  else state_nx = ST_LAP;
        default:  state_nx = ST_IDLE;
      endcase
    end
    enter_lap  = (state_nx == ST_LAP) && (state_r != ST_LAP);
    enter_idle = (state_nx == ST_IDLE) && (state_r != ST_IDLE);
  end

  // State register and registered control/display outputs.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      o_countinit <= 1'b1;
      o_countenb  <= 1'b0;
      o_display   <= '0;
      o_overflow  <= 1'b0;
    end else begin
      state_r     <= state_nx;
      o_countinit <= (state_nx == ST_IDLE);
      o_countenb  <= counts_enabled(state_nx);
      if (enter_idle) begin
        o_overflow <= 1'b0;
      end else if (count_max && o_countenb) begin
        o_overflow <= 1'b1;
      end
      // Display is frozen only while staying in LAP.
      if ((state_nx != ST_LAP) || enter_lap) begin
        o_display <= i_count;
      end
    end
  end

`ifdef RTC_LAP_FIFO_EN
  localparam int                PTR_W     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [PTR_W:0]    FILL_FULL = (PTR_W + 1)'(LAP_DEPTH);
  localparam logic [PTR_W:0]    FILL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  logic [COUNT_W-1:0] mem_r [LAP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]     fill_r, fill_nx;
  logic               do_push, do_pop;

  // A pop frees a slot, so a push into a full FIFO is accepted when paired with a pop.
  always_comb begin
    do_pop  = i_lap_rd && (fill_r != '0) && !enter_idle;
    do_push = enter_lap && ((fill_r != FILL_FULL) || do_pop);
    if (enter_idle) begin
      fill_nx = '0;
    end else if (do_push && !do_pop) begin
      fill_nx = fill_r + FILL_ONE;
    end else if (do_pop && !do_push) begin
      fill_nx = fill_r - FILL_ONE;
    end else begin
      fill_nx = fill_r;
    end
  end

  // Lap storage array.
  always_ff @(posedge i_sclk) begin
    if (do_push) begin
      mem_r[wr_ptr_r] <= i_count;
    end
  end

  // Pointers, occupancy and registered FIFO outputs.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fill_r      <= '0;
      o_lap_data  <= '0;
      o_lap_valid <= 1'b0;
      o_lap_empty <= 1'b1;
      o_lap_full  <= 1'b0;
    end else begin
      o_lap_valid <= do_pop;
      if (do_pop) begin
        o_lap_data <= mem_r[rd_ptr_r];
      end
      if (enter_idle) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (do_push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (do_pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fill_r      <= fill_nx;
      o_lap_empty <= (fill_nx == '0);
      o_lap_full  <= (fill_nx == FILL_FULL);
    end
  end
`else
  logic [COUNT_W-1:0] lap_reg_r;
  logic               cap_pend_r;
  logic               unused_lap_rd;

  assign unused_lap_rd = i_lap_rd;

  // Single lap register; the captured value is presented one cycle after capture.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      lap_reg_r   <= '0;
      cap_pend_r  <= 1'b0;
      o_lap_data  <= '0;
      o_lap_valid <= 1'b0;
    end else begin
      cap_pend_r  <= enter_lap;
      o_lap_valid <= cap_pend_r;
      if (enter_lap) begin
        lap_reg_r <= i_count;
      end
      if (cap_pend_r) begin
        o_lap_data <= lap_reg_r;
      end
    end
  end

  assign o_lap_empty = 1'b1;
  assign o_lap_full  = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_stopwatch_ctrl.sv
// Scoreboard bench for rtc_stopwatch_ctrl: timed expectations plus a lap-data queue.
// Covers the RTC_LAP_FIFO_EN build when that macro is defined.
module tb_rtc_stopwatch_ctrl;

  logic        i_sclk = 1'b0;
  logic        i_reset, i_start_stop, i_lap, i_clear, i_lap_rd;
  logic [23:0] i_count;
  logic        o_countinit, o_countenb, o_overflow, o_lap_valid, o_lap_empty, o_lap_full;
  logic [23:0] o_display, o_lap_data;

  rtc_stopwatch_ctrl dut (
    .i_sclk(i_sclk), .i_reset(i_reset), .i_start_stop(i_start_stop), .i_lap(i_lap),
    .i_clear(i_clear), .i_count(i_count), .i_lap_rd(i_lap_rd),
    .o_countinit(o_countinit), .o_countenb(o_countenb), .o_display(o_display),
    .o_overflow(o_overflow), .o_lap_data(o_lap_data), .o_lap_valid(o_lap_valid),
    .o_lap_empty(o_lap_empty), .o_lap_full(o_lap_full)
  );

  always #5 i_sclk = ~i_sclk;

  localparam int F_INIT = 0, F_ENB = 1, F_DISP = 2, F_OVF = 3, F_EMPTY = 4, F_FULL = 5, F_VALID = 6;

  typedef struct {
    int          cyc;
    int          fld;
    logic [23:0] val;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] lap_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge i_sclk) cyc <= cyc + 1;

  function automatic logic [23:0] actual(input int fld);
    case (fld)
      F_INIT:  return {23'd0, o_countinit};
      F_ENB:   return {23'd0, o_countenb};
      F_DISP:  return o_display;
      F_OVF:   return {23'd0, o_overflow};
      F_EMPTY: return {23'd0, o_lap_empty};
      F_FULL:  return {23'd0, o_lap_full};
      F_VALID: return {23'd0, o_lap_valid};
      default: return 24'hxxxxxx;
    endcase
  endfunction

  // Timed-expectation monitor: compares every entry due this cycle.
  always @(negedge i_sclk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        checks++;
        if (actual(exp_q[i].fld) !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h expected %h", exp_q[i].nm, cyc,
                   actual(exp_q[i].fld), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  // Lap-data monitor: every o_lap_valid must match the next queued lap value.
  always @(negedge i_sclk) begin
    if (o_lap_valid === 1'b1) begin
      checks++;
      if (lap_q.size() == 0) begin
        errors++;
        $display("FAIL lap_unexpected @cyc %0d: got valid data %h expected no valid", cyc, o_lap_data);
      end else begin
        if (o_lap_data !== lap_q[0]) begin
          errors++;
          $display("FAIL lap_data @cyc %0d: got %h expected %h", cyc, o_lap_data, lap_q[0]);
        end
        void'(lap_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic expect_at(input int off, input int fld, input logic [23:0] val, input string nm);
    exp_t e;
    e.cyc = cyc + off;
    e.fld = fld;
    e.val = val;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // mask = {clear, lap, start}; i_count changes to cnt_after once the FSM has reacted.
  task automatic press(input logic [2:0] mask, input logic [23:0] cnt_after);
    i_start_stop = mask[0];
    i_lap        = mask[1];
    i_clear      = mask[2];
    repeat (3) tick();
    i_count = cnt_after;
    tick();
    i_start_stop = 1'b0;
    i_lap        = 1'b0;
    i_clear      = 1'b0;
    repeat (3) tick();
  endtask

  localparam logic [2:0] B_START = 3'b001, B_LAP = 3'b010, B_CLEAR = 3'b100;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_start_stop = 1'b0; i_lap = 1'b0; i_clear = 1'b0;
    i_lap_rd = 1'b0; i_count = 24'h000005;
    repeat (2) tick();
    expect_at(0, F_INIT, 24'd1, "rst_countinit");
    expect_at(0, F_ENB, 24'd0, "rst_countenb");
    expect_at(0, F_DISP, 24'd0, "rst_display");
    expect_at(0, F_OVF, 24'd0, "rst_overflow");
    expect_at(0, F_EMPTY, 24'd1, "rst_empty");
    expect_at(0, F_FULL, 24'd0, "rst_full");
    expect_at(0, F_VALID, 24'd0, "rst_valid");
    tick();
    i_reset = 1'b0;
    i_count = 24'h000000;
    repeat (2) tick();

    // Start from IDLE: outputs change on the third edge.
    expect_at(2, F_INIT, 24'd1, "start_not_yet");
    expect_at(3, F_INIT, 24'd0, "start_countinit");
    expect_at(3, F_ENB, 24'd1, "start_countenb");
    press(B_START, 24'h000000);

    // Lap entry freezes display at 0x000123 while i_count advances.
    i_count = 24'h000123;
    expect_at(3, F_DISP, 24'h000123, "lap_freeze");
    expect_at(3, F_ENB, 24'd1, "lap_countenb");
    expect_at(5, F_DISP, 24'h000123, "lap_hold");
`ifdef RTC_LAP_FIFO_EN
    expect_at(3, F_EMPTY, 24'd0, "lap_push_notempty");
`else
    lap_q.push_back(24'h000123);
`endif
    press(B_LAP, 24'h000200);

    // Second lap returns to live display.
    i_count = 24'h000300;
    expect_at(3, F_DISP, 24'h000300, "lap2_live");
    expect_at(4, F_DISP, 24'h000301, "lap2_follow");
    press(B_LAP, 24'h000301);

    // Pause, then lap is ignored in PAUSE.
    expect_at(3, F_ENB, 24'd0, "pause_countenb");
    expect_at(3, F_INIT, 24'd0, "pause_countinit");
    press(B_START, 24'h000301);
    i_count = 24'h000400;
    expect_at(3, F_ENB, 24'd0, "pause_lap_ignored");
    expect_at(3, F_DISP, 24'h000400, "pause_display_live");
    press(B_LAP, 24'h000400);

    // Start and clear together in PAUSE: clear wins.
    expect_at(3, F_INIT, 24'd1, "clr_start_idle");
    expect_at(3, F_ENB, 24'd0, "clr_start_countenb");
`ifdef RTC_LAP_FIFO_EN
    expect_at(3, F_EMPTY, 24'd1, "idle_flush");
`endif
    press(B_START | B_CLEAR, 24'h000000);

    // Run, clear ignored in RUN.
    press(B_START, 24'h000000);
    expect_at(3, F_ENB, 24'd1, "run_clear_ignored");
    expect_at(3, F_INIT, 24'd0, "run_clear_countinit");
    press(B_CLEAR, 24'h000000);

    // Saturation forces PAUSE and sets the sticky flag.
    i_count = 24'hFFFFFF;
    expect_at(1, F_ENB, 24'd0, "ovf_pause");
    expect_at(1, F_OVF, 24'd1, "ovf_set");
    tick();
    i_count = 24'h000010;
    repeat (2) tick();
    expect_at(3, F_ENB, 24'd1, "ovf_resume");
    expect_at(3, F_OVF, 24'd1, "ovf_sticky");
    press(B_START, 24'h000010);
    expect_at(3, F_ENB, 24'd0, "ovf_pause2");
    press(B_START, 24'h000010);
    expect_at(2, F_OVF, 24'd1, "ovf_before_clear");
    expect_at(3, F_OVF, 24'd0, "ovf_cleared");
    expect_at(3, F_INIT, 24'd1, "ovf_idle");
    press(B_CLEAR, 24'h000000);

`ifdef RTC_LAP_FIFO_EN
    // Five lap captures into a four-entry FIFO, then five pops.
    press(B_START, 24'h000000);
    for (int k = 0; k < 5; k++) begin
      i_count = 24'(10 * (k + 1));
      press(B_LAP, i_count);
      if (k < 4) press(B_LAP, i_count);
    end
    expect_at(0, F_FULL, 24'd1, "fifo_full");
    tick();
    for (int k = 0; k < 4; k++) lap_q.push_back(24'(10 * (k + 1)));
    for (int k = 0; k < 5; k++) begin
      if (k == 4) expect_at(1, F_VALID, 24'd0, "pop_empty_ignored");
      i_lap_rd = 1'b1;
      tick();
      i_lap_rd = 1'b0;
      tick();
    end
    expect_at(0, F_EMPTY, 24'd1, "fifo_empty_after_pops");
    expect_at(0, F_FULL, 24'd0, "fifo_notfull_after_pops");
    tick();
    press(B_LAP, 24'h000000);
`else
    press(B_START, 24'h000000);
`endif

    // Reset during a lap capture / pop.
    i_count = 24'h000055;
    i_lap = 1'b1;
    repeat (3) tick();
    i_lap_rd = 1'b1;
    i_reset  = 1'b1;
    expect_at(0, F_VALID, 24'd0, "rstpop_valid");
    expect_at(0, F_EMPTY, 24'd1, "rstpop_empty");
    expect_at(0, F_INIT, 24'd1, "rstpop_countinit");
    expect_at(1, F_VALID, 24'd0, "rstpop_valid_next");
    repeat (2) tick();
    i_lap = 1'b0;
    i_lap_rd = 1'b0;
    tick();
    i_reset = 1'b0;
    i_count = 24'h000000;
    tick();
    expect_at(3, F_INIT, 24'd0, "post_rst_start");
    expect_at(3, F_ENB, 24'd1, "post_rst_countenb");
    press(B_START, 24'h000000);
    repeat (4) tick();

    checks++;
    if (exp_q.size() != 0 || lap_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d timed and %0d lap entries pending, expected 0 and 0",
               exp_q.size(), lap_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
